// File: rtl/hydra_pkg.sv
// rtl/hydra_pkg.sv - shared types and constants for the hydra switch port logic
package hydra_pkg;

  localparam int HDR_LEN_W  = 9;
  localparam int HDR_PRIO_W = 3;
  localparam int HDR_DEST_W = 4;
  localparam int DATA_W     = 16;

  typedef struct packed {
    logic [HDR_LEN_W-1:0]  len;
    logic [HDR_PRIO_W-1:0] prio;
    logic [HDR_DEST_W-1:0] dest;
  } hdr_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic              err;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HDR,
    PAYLOAD,
    TAIL
  } state_t;

  function automatic hdr_t decode_hdr(input logic [DATA_W-1:0] word);
    return hdr_t'(word);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; push while full is allowed when a pop frees the slot
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is not reset; the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/port_ingress.sv
// rtl/port_ingress.sv - per-port packet framer, header decoder, length checker and ingress buffer
module port_ingress
  import hydra_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int PAUSE_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_sop,
  input  logic                  wr_vld,
  input  logic                  wr_eop,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  pause,
  output logic                  hdr_vld,
  output logic [HDR_DEST_W-1:0] hdr_dest,
  output logic [HDR_PRIO_W-1:0] hdr_prio,
  output logic [HDR_LEN_W-1:0]  hdr_len,
  output logic                  out_vld,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_err,
  output logic [15:0]           drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] PAUSE_LVL = CW'(DEPTH - PAUSE_MARGIN);

  state_t               state, state_n;
  logic [DATA_W-1:0]    hold_data;
  logic                 hold_sop;
  logic                 hold_vld;
  logic [HDR_LEN_W-1:0] pay_cnt;
  logic                 pkt_err;

  logic                 push;
  fifo_entry_t          push_entry;
  fifo_entry_t          head;
  logic                 hold_load, hold_clear, cnt_clr, cnt_inc, hdr_load, drop;
  logic                 tail_err;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count, cnt_next;
  logic                 pop_ok, push_ok, overflow;
  hdr_t                 hdr_in;

  assign hdr_in   = decode_hdr(wr_data);
  assign tail_err = pkt_err || (pay_cnt != hdr_len);
  assign out_vld  = !fifo_empty;
  assign pop_ok   = out_vld && out_ready;
  assign push_ok  = push && (!fifo_full || pop_ok);
  assign overflow = push && !push_ok;
  assign cnt_next = fifo_count + CW'(push_ok) - CW'(pop_ok);

  assign out_data = out_vld ? head.data : '0;
  assign out_sop  = out_vld && head.sop;
  assign out_eop  = out_vld && head.eop;
  assign out_err  = out_vld && head.err;

  // The held word is released by the next word (eop=0) or by the packet end (eop=1).
  always_comb begin
    state_n    = state;
    push       = 1'b0;
    push_entry = '0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    hdr_load   = 1'b0;
    drop       = 1'b0;
    push_entry.sop  = hold_sop;
    push_entry.data = hold_data;
    case (state)
      IDLE: begin
        drop = wr_vld;
        if (wr_sop) state_n = WAIT_HDR;
      end
      WAIT_HDR: begin
        if (wr_vld && !wr_sop) begin
          hdr_load  = 1'b1;
          hold_load = 1'b1;
          cnt_clr   = 1'b1;
          state_n   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (wr_sop) begin
          push           = hold_vld;
          push_entry.eop = 1'b1;
          push_entry.err = 1'b1;
          hold_clear     = 1'b1;
          state_n        = WAIT_HDR;
        end else if (wr_vld) begin
          push      = hold_vld;
          hold_load = 1'b1;
          cnt_inc   = 1'b1;
          if (wr_eop) state_n = TAIL;
        end else if (wr_eop) begin
          push           = hold_vld;
          push_entry.eop = 1'b1;
          push_entry.err = tail_err;
          hold_clear     = 1'b1;
          state_n        = IDLE;
        end
      end
      TAIL: begin
        push           = hold_vld;
        push_entry.eop = 1'b1;
        push_entry.err = tail_err;
        hold_clear     = 1'b1;
        drop           = wr_vld;
        state_n        = wr_sop ? WAIT_HDR : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_sop  <= 1'b0;
      hold_vld  <= 1'b0;
      pay_cnt   <= '0;
      pkt_err   <= 1'b0;
      hdr_vld   <= 1'b0;
      hdr_dest  <= '0;
      hdr_prio  <= '0;
      hdr_len   <= '0;
      drop_cnt  <= '0;
      pause     <= 1'b0;
    end else begin
      state   <= state_n;
      hdr_vld <= hdr_load;
      pause   <= (cnt_next >= PAUSE_LVL);
      if (hdr_load) begin
        hdr_dest <= hdr_in.dest;
        hdr_prio <= hdr_in.prio;
        hdr_len  <= hdr_in.len;
      end
      if (hold_load) begin
        hold_data <= wr_data;
        hold_sop  <= hdr_load;
        hold_vld  <= 1'b1;
      end else if (hold_clear) begin
        hold_vld  <= 1'b0;
      end
      if (cnt_clr)                      pay_cnt <= '0;
      else if (cnt_inc && pay_cnt != '1) pay_cnt <= pay_cnt + 1'b1;
      // A word lost to a full FIFO poisons the packet until the next header.
      if (hdr_load)      pkt_err <= 1'b0;
      else if (overflow) pkt_err <= 1'b1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (out_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_port_ingress.sv
// tb/tb_port_ingress.sv - directed scoreboard bench for port_ingress
module tb_port_ingress;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_sop, wr_vld, wr_eop;
  logic [15:0] wr_data;
  logic        pause, hdr_vld;
  logic [3:0]  hdr_dest;
  logic [2:0]  hdr_prio;
  logic [8:0]  hdr_len;
  logic        out_vld, out_ready;
  logic [15:0] out_data;
  logic        out_sop, out_eop, out_err;
  logic [15:0] drop_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          out_cnt  = 0;
  int          hdr_cnt  = 0;
  logic [18:0] exp_q[$];

  port_ingress #(.DEPTH(16), .PAUSE_MARGIN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_sop    (wr_sop),
    .wr_vld    (wr_vld),
    .wr_eop    (wr_eop),
    .wr_data   (wr_data),
    .pause     (pause),
    .hdr_vld   (hdr_vld),
    .hdr_dest  (hdr_dest),
    .hdr_prio  (hdr_prio),
    .hdr_len   (hdr_len),
    .out_vld   (out_vld),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_err   (out_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void exp_push(input logic s, input logic e, input logic er, input logic [15:0] d);
    exp_q.push_back({s, e, er, d});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic s, input logic v, input logic e, input logic [15:0] d);
    wr_sop = s; wr_vld = v; wr_eop = e; wr_data = d;
    tick();
    wr_sop = 1'b0; wr_vld = 1'b0; wr_eop = 1'b0; wr_data = '0;
  endtask

  task automatic hdr_chk(input logic [3:0] d, input logic [2:0] p, input logic [8:0] l);
    chk("hdr_vld", hdr_vld, 1);
    chk("hdr_dest", hdr_dest, d);
    chk("hdr_prio", hdr_prio, p);
    chk("hdr_len", hdr_len, l);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    chk(tag, exp_q.size(), 0);
  endtask

  // Scoreboard side: every consumed head word must match the next expected entry.
  always @(negedge clk) begin
    logic [18:0] e;
    if (rst_n) begin
      if (hdr_vld) hdr_cnt++;
      if (out_vld && out_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_entry", {13'b0, out_sop, out_eop, out_err, out_data}, {13'b0, e});
        end
        out_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; wr_sop = 0; wr_vld = 0; wr_eop = 0; wr_data = '0; out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_pause", pause, 0);
    chk("rst_hdr_vld", hdr_vld, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_hdr_len", hdr_len, 0);
    rst_n = 1'b1;
    tick();

    // Nominal packet
    out_ready = 1'b1;
    base = out_cnt;
    cyc(1, 0, 0, 0);
    exp_push(1, 0, 0, 16'h0FC3);
    cyc(0, 1, 0, 16'h0FC3);
    hdr_chk(4'd3, 3'd4, 9'd31);
    chk("lat_out_vld_n1", out_vld, 0);
    for (int i = 1; i <= 31; i++) begin
      exp_push(0, i == 31, 0, 16'(i));
      cyc(0, 1, 0, 16'(i));
      if (i == 1) begin
        chk("hdr_vld_pulse", hdr_vld, 0);
        chk("lat_out_vld_n2", out_vld, 1);
      end
    end
    repeat (3) tick();
    cyc(0, 0, 1, 0);
    drain("nominal_drain");
    chk("nominal_words", out_cnt - base, 32);
    chk("nominal_hdr_cnt", hdr_cnt, 1);

    // Length mismatch, eop on the last data word
    cyc(1, 0, 0, 0);
    exp_push(1, 0, 0, 16'h1143);
    cyc(0, 1, 0, 16'h1143);
    hdr_chk(4'd3, 3'd4, 9'd34);
    for (int i = 1; i <= 31; i++) begin
      exp_push(0, i == 31, i == 31, 16'h2000 + 16'(i));
      cyc(0, 1, i == 31, 16'h2000 + 16'(i));
    end
    drain("mismatch_drain");

    // Backpressure and overflow
    out_ready = 1'b0;
    cyc(1, 0, 0, 0);
    exp_push(1, 0, 0, 16'h0985);
    cyc(0, 1, 0, 16'h0985);
    chk("bp_pause_hdr", pause, 0);
    for (int j = 1; j <= 19; j++) begin
      if (j <= 15) exp_push(0, 0, 0, 16'h3000 + 16'(j));
      cyc(0, 1, 0, 16'h3000 + 16'(j));
      chk("bp_pause_fill", pause, 32'(j >= 12));
    end
    chk("bp_out_vld", out_vld, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("bp_pause_drain", pause, 32'((16 - k) >= 12));
    end
    exp_push(0, 1, 1, 16'h3013);
    cyc(0, 0, 1, 0);
    drain("bp_drain");

    // Abort by a new sop
    cyc(1, 0, 0, 0);
    exp_push(1, 0, 0, 16'h0525);
    cyc(0, 1, 0, 16'h0525);
    hdr_chk(4'd5, 3'd2, 9'd10);
    for (int j = 1; j <= 5; j++) begin
      exp_push(0, j == 5, j == 5, 16'h4000 + 16'(j));
      cyc(0, 1, 0, 16'h4000 + 16'(j));
    end
    cyc(1, 0, 0, 0);
    exp_push(1, 0, 0, 16'h0107);
    cyc(0, 1, 0, 16'h0107);
    hdr_chk(4'd7, 3'd0, 9'd2);
    exp_push(0, 0, 0, 16'h4101);
    cyc(0, 1, 0, 16'h4101);
    exp_push(0, 1, 0, 16'h4102);
    cyc(0, 1, 0, 16'h4102);
    cyc(0, 0, 1, 0);
    drain("abort_drain");

    // Stray words, then a header-only packet
    chk("stray_drop_before", drop_cnt, 0);
    base = out_cnt;
    for (int j = 0; j < 3; j++) cyc(0, 1, 0, 16'hDEAD);
    chk("stray_drop_cnt", drop_cnt, 3);
    chk("stray_no_fifo", out_cnt - base, 0);
    chk("stray_out_vld", out_vld, 0);
    cyc(1, 0, 0, 0);
    exp_push(1, 1, 0, 16'h0003);
    cyc(0, 1, 0, 16'h0003);
    hdr_chk(4'd3, 3'd0, 9'd0);
    cyc(0, 0, 1, 0);
    drain("hdronly_drain");
    chk("hdronly_words", out_cnt - base, 1);

    // Reset in the middle of a packet
    cyc(1, 0, 0, 0);
    exp_push(1, 0, 0, 16'h0601);
    cyc(0, 1, 0, 16'h0601);
    for (int j = 1; j <= 9; j++) begin
      exp_push(0, 0, 0, 16'h5000 + 16'(j));
      cyc(0, 1, 0, 16'h5000 + 16'(j));
    end
    wr_vld = 1'b1; wr_data = 16'h500A;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vld", out_vld, 0);
    chk("mid_rst_pause", pause, 0);
    chk("mid_rst_hdr_len", hdr_len, 0);
    chk("mid_rst_hdr_dest", hdr_dest, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    chk("mid_rst_out_word", {out_sop, out_eop, out_err, out_data}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1; wr_vld = 1'b0; wr_data = '0;
    tick();
    cyc(1, 0, 0, 0);
    exp_push(1, 0, 0, 16'h0181);
    cyc(0, 1, 0, 16'h0181);
    hdr_chk(4'd1, 3'd0, 9'd3);
    for (int j = 1; j <= 3; j++) begin
      exp_push(0, j == 3, 0, 16'h6000 + 16'(j));
      cyc(0, 1, 0, 16'h6000 + 16'(j));
    end
    cyc(0, 0, 1, 0);
    drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/port_ingress.md
Name: port_ingress

Overview:
- Per-port front end of the hydra switch: one instance per input port, sitting between the external write interface (wr_sop/wr_vld/wr_eop/wr_data/pause) and the shared SRAM write/match logic.
- Frames each packet, decodes the header word {len[15:7], prio[6:4], dest[3:0]} and checks the payload length.
- Buffers words in a small FIFO and drives pause back to the source as the FIFO fills.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, >= 4).
- PAUSE_MARGIN, 4, pause asserts when FIFO occupancy >= DEPTH-PAUSE_MARGIN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_sop  in  1  packet start pulse; the header arrives on a later wr_vld
- wr_vld  in  1  wr_data valid
- wr_eop  in  1  packet end pulse; same cycle as the last wr_vld or any later cycle
- wr_data  in  16  header word, then payload words
- pause  out  1  backpressure to the source, registered
- hdr_vld  out  1  one-cycle pulse when a header is decoded
- hdr_dest  out  4  destination port
- hdr_prio  out  3  priority
- hdr_len  out  9  declared payload word count
- out_vld  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head word when out_vld && out_ready
- out_data  out  16  head word
- out_sop  out  1  head word is a header
- out_eop  out  1  head word is the last word of its packet
- out_err  out  1  valid with out_eop: packet is malformed
- drop_cnt  out  16  count of stray words dropped, saturating

Behaviour:
- Reset values:
  - pause, hdr_vld, out_vld, drop_cnt = 0.
  - hdr_dest, hdr_prio, hdr_len = 0.
  - FIFO empty, state IDLE, hold register empty.
- FSM states: IDLE, WAIT_HDR, PAYLOAD, TAIL.
  - IDLE: wr_sop -> WAIT_HDR.
  - WAIT_HDR: first wr_vld is the header.
    - Decode the header, pulse hdr_vld the next cycle, and latch the hdr_* outputs until the next header.
    - Go to PAYLOAD; the payload counter clears to 0.
  - PAYLOAD: each wr_vld increments the payload counter, saturating at 511.
    - wr_eop (with or without wr_vld) -> TAIL handling in the same cycle, then IDLE.
  - A wr_sop while in WAIT_HDR or PAYLOAD aborts the current packet:
    - The held word is flagged eop+err.
    - The FSM goes to WAIT_HDR for the new packet.
- Hold register:
  - Each accepted word is held for one cycle or longer and pushed to the FIFO only when the next wr_vld or the wr_eop arrives, so the eop flag can be attached to the last word.
  - Header latency: wr_vld of the header at cycle N, next word at N+1 -> out_vld at N+2 at the earliest.
- The err flag is set on the eop entry if any of these holds:
  - payload count != hdr_len;
  - the packet was aborted;
  - a word was lost to FIFO overflow.
- Header-only packet (eop right after the header) with hdr_len = 0 -> single entry with sop=eop=1 and err=0.
- Stray traffic:
  - wr_vld in IDLE is dropped and increments drop_cnt, saturating at 16'hFFFF.
  - wr_eop in IDLE or WAIT_HDR is ignored.
- FIFO:
  - Entry is {sop, eop, err, data[15:0]}; width 19.
  - Push and pop in the same cycle are allowed at any occupancy, including full (pop frees the slot).
  - Push when full without a pop: the word is lost and the current packet's err is forced to 1.
  - Pointers wrap modulo DEPTH; occupancy is tracked in a $clog2(DEPTH)+1 bit counter.
- pause:
  - Registered; pause <= (occupancy >= DEPTH-PAUSE_MARGIN), evaluated on the next-state occupancy.
  - The source still sends up to 2 words after pause rises; PAUSE_MARGIN >= 3 absorbs them.
- Asserting rst_n low mid-packet immediately clears the FSM, FIFO, hold register and all outputs. The partial packet is discarded and no err entry is generated.

Decomposition:
- hydra_pkg holds:
  - hdr_t packed struct {len[8:0], prio[2:0], dest[3:0]};
  - constants HDR_LEN_W=9, HDR_PRIO_W=3, HDR_DEST_W=4, DATA_W=16;
  - fifo_entry_t packed struct {sop, eop, err, data}.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; outputs full, empty, count), instantiated once.
- The FSM, hold register and length check live in port_ingress itself.

Test Plan:
- Nominal packet: sop; header 16'h0FC3 (len 31, prio 4, dest 3); 31 payload words 1..31; eop 3 cycles after the last word; out_ready=1.
  - hdr_vld once with dest=3, prio=4, len=31.
  - 32 FIFO words out; the first has sop=1; word 31 has eop=1, err=0.
- Length mismatch: header 16'h1143 (len 34), 31 payload words, eop.
  - Last word out has eop=1, err=1; hdr_len=34.
- Backpressure: DEPTH=16, out_ready=0, 20 consecutive words.
  - pause=1 one cycle after occupancy reaches 12.
  - Words beyond 16 are lost and err=1 on eop.
  - Release out_ready -> pause drops once occupancy < 12.
- Abort: new sop after 5 payload words of a len-10 packet.
  - The 5th word exits with eop=1, err=1.
  - The following header is decoded normally.
- Stray and header-only: 3 wr_vld in IDLE -> drop_cnt=3, no FIFO activity.
  - Then sop, header 16'h0003, eop -> one entry with sop=eop=1, err=0.
- Reset mid-packet: rst_n low for 1 cycle at payload word 10.
  - All outputs are 0 and out_vld=0 the same cycle.
  - The next full packet passes cleanly.
